// File: rtl/hazard_ctl_pkg.sv
// Shared state encodings and register-compare helper for the decode-stage hazard controller.
package hazard_ctl_pkg;

    localparam int HZ_STATE_W = 3;
    localparam int HZ_REG_W   = 5;
    localparam int HZ_CNT_W   = 4;

    localparam logic [2:0] HZ_RUN   = 3'd0;
    localparam logic [2:0] HZ_STALL = 3'd1;
    localparam logic [2:0] HZ_DRAIN = 3'd2;
    localparam logic [2:0] HZ_HALT  = 3'd3;

    // Register 0 is hardwired, so a zero destination never creates a dependency.
    function automatic logic reg_match(input logic [4:0] dest, input logic [4:0] src);
        return (dest != 5'd0) && (dest == src);
    endfunction

endpackage

// File: rtl/hazard_ctl_load_use_detect.sv
// Combinational load-use compare between the EX load destination and the ID source registers.
module load_use_detect
    import hazard_ctl_pkg::*;
(
    input  logic                id_valid,
    input  logic [HZ_REG_W-1:0] id_rs,
    input  logic [HZ_REG_W-1:0] id_rt,
    input  logic                ex_mem_r,
    input  logic [HZ_REG_W-1:0] ex_dest,
    output logic                hz
);

    assign hz = id_valid & ex_mem_r & (reg_match(ex_dest, id_rs) | reg_match(ex_dest, id_rt));

endmodule

// File: rtl/hazard_ctl.sv
// Decode-stage sequencing: load-use stall, branch/jump flush, terminate drain and halt.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctl
    import hazard_ctl_pkg::*;
#(
    parameter int LOAD_LAT     = 1,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [HZ_REG_W-1:0]   id_rs,
    input  logic [HZ_REG_W-1:0]   id_rt,
    input  logic                  ex_mem_r,
    input  logic [HZ_REG_W-1:0]   ex_dest,
    input  logic                  branch_taken,
    input  logic                  jump_taken,
    input  logic                  terminate,
    output logic                  stall,
    output logic                  pc_hold,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  halted,
    output logic [HZ_STATE_W-1:0] fsm_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flushes
`endif
);

    localparam logic [HZ_CNT_W-1:0] STALL_INIT = HZ_CNT_W'(LOAD_LAT - 1);
    localparam logic [HZ_CNT_W-1:0] DRAIN_INIT = HZ_CNT_W'(DRAIN_CYCLES);

    logic [HZ_STATE_W-1:0] state_r;
    logic [HZ_STATE_W-1:0] next_state_s;
    logic [HZ_CNT_W-1:0]   cnt_r;
    logic [HZ_CNT_W-1:0]   next_cnt_s;
    logic                  hz_s;

    load_use_detect u_detect (
        .id_valid (id_valid),
        .id_rs    (id_rs),
        .id_rt    (id_rt),
        .ex_mem_r (ex_mem_r),
        .ex_dest  (ex_dest),
        .hz       (hz_s)
    );

    // Next-state and Mealy output decode; hazard outranks terminate, which outranks branch/jump.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        stall        = 1'b0;
        pc_hold      = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        halted       = 1'b0;
        case (state_r)
            HZ_RUN: begin
                if (hz_s) begin
                    stall       = 1'b1;
                    pc_hold     = 1'b1;
                    idex_bubble = 1'b1;
                    if (LOAD_LAT > 1) begin
                        next_state_s = HZ_STALL;
                        next_cnt_s   = STALL_INIT;
                    end else begin
                        next_state_s = HZ_RUN;
                    end
                end else if (terminate) begin
                    pc_hold      = 1'b1;
                    ifid_flush   = 1'b1;
                    next_state_s = HZ_DRAIN;
                    next_cnt_s   = DRAIN_INIT;
                end else if (branch_taken | jump_taken) begin
                    ifid_flush = 1'b1;
                end else begin
                    next_state_s = HZ_RUN;
                end
            end
            HZ_STALL: begin
                stall       = 1'b1;
                pc_hold     = 1'b1;
                idex_bubble = 1'b1;
                next_cnt_s  = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    next_state_s = HZ_RUN;
                end else begin
                    next_state_s = HZ_STALL;
                end
            end
            HZ_DRAIN: begin
                pc_hold    = 1'b1;
                ifid_flush = 1'b1;
                next_cnt_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    next_state_s = HZ_HALT;
                end else begin
                    next_state_s = HZ_DRAIN;
                end
            end
            HZ_HALT: begin
                halted  = 1'b1;
                pc_hold = 1'b1;
            end
            default: begin
                next_state_s = HZ_RUN;
                next_cnt_s   = 4'd0;
            end
        endcase
    end

    // State and down-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= HZ_RUN;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
        end
    end

    assign fsm_state = state_r;

`ifdef HAZARD_PERF_EN
    logic        flush_pulse_s;
    logic [31:0] perf_stall_r;
    logic [31:0] perf_flush_r;

    // Only RUN-state branch/jump flushes count; terminate and drain flushes are excluded.
    assign flush_pulse_s = (state_r == HZ_RUN) & ~hz_s & ~terminate & (branch_taken | jump_taken);

    // Wrapping event counters; stall and flush pulses are both zero in HALT, so they freeze there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_r <= 32'd0;
            perf_flush_r <= 32'd0;
        end else begin
            if (stall) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
            if (flush_pulse_s) begin
                perf_flush_r <= perf_flush_r + 32'd1;
            end else begin
                perf_flush_r <= perf_flush_r;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_r;
    assign perf_flushes      = perf_flush_r;
`endif

endmodule
